// File: rtl/alu_4.sv
// alu_4: registered ADD/SUB/AND/XOR unit; in a,b,f,cci sampled on clk, out d,co one cycle later, async active-low rst_n clears d,co
module alu_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       f,
  input  logic             cci,
  output logic [WIDTH-1:0] d,
  output logic             co
);
  logic [WIDTH:0]   sum, dif;
  logic [WIDTH-1:0] d_d, d_q;
  logic             co_d, co_q;
  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cci);
    dif = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(cci);
    {co_d, d_d} = f == 2'b01 ? dif :
                  f == 2'b10 ? {1'b0, a & b} :
                  f == 2'b11 ? {1'b0, a ^ b} : sum;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d_q  <= '0;
      co_q <= 1'b0;
    end else begin
      d_q  <= d_d;
      co_q <= co_d;
    end
  assign d  = d_q;
  assign co = co_q;
endmodule

// File: tb/tb_alu_4.sv
// tb_alu_4: random and directed checks of alu_4 against an integer reference model
module tb_alu_4;
  logic       clk = 1'b0, rst_n = 1'b0, cci = 1'b0;
  logic [3:0] a = '0, b = '0, d;
  logic [1:0] f = '0;
  logic       co;
  int         n_cmp = 0, n_bad = 0;
  alu_4 dut (.clk(clk), .rst_n(rst_n), .d(d), .co(co), .a(a), .b(b), .f(f), .cci(cci));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got co,d=%b,%h want co,d=%b,%h", tag, got[4], got[3:0], exp[4], exp[3:0]);
    end
  endtask
  function automatic logic [4:0] model(input int x, input int y, input int op, input int c);
    int r;
    case (op)
      0: r = x + y + c;
      1: r = ((x - y - c) & 15) | ((x < y + c) ? 16 : 0);
      2: r = x & y;
      default: r = x ^ y;
    endcase
    return 5'(r);
  endfunction
  task automatic step(input string tag, input int x, input int y, input int op, input int c);
    @(negedge clk);
    a = 4'(x); b = 4'(y); f = 2'(op); cci = 1'(c);
    @(posedge clk);
    #1 chk(tag, {co, d}, model(x, y, op, c));
  endtask
  int sa[10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
  int sb[10] = '{3, 2, 1, 4, 8, 9, 0, 0, 1, 3};
  initial begin
    a = 4'hF; b = 4'hF; f = 2'b00; cci = 1'b1;
    #3 chk("rst_async", {co, d}, 5'h00);
    @(posedge clk);
    #1 chk("rst_hold_edge", {co, d}, 5'h00);
    rst_n = 1'b1;
    #2 chk("rst_release_hold", {co, d}, 5'h00);
    @(posedge clk);
    #1 chk("rst_first_edge", {co, d}, 5'h1F);
    step("add", 5, 8, 0, 0);
    step("add_wrap", 15, 1, 0, 1);
    step("sub", 9, 3, 1, 0);
    step("sub_borrow", 2, 3, 1, 1);
    step("and", 12, 10, 2, 1);
    step("xor", 12, 10, 3, 1);
    step("and_c0", 12, 10, 2, 0);
    step("xor_c0", 12, 10, 3, 0);
    for (int i = 0; i < 10; i++) step($sformatf("sweep%0d", i), sa[i], sb[i], 0, 0);
    step("sub_pre_rst", 7, 2, 1, 0);
    #1 rst_n = 1'b0;
    #1 chk("mid_rst", {co, d}, 5'h00);
    #1 rst_n = 1'b1;
    step("after_mid_rst", 7, 2, 1, 0);
    step("sub_zero", 0, 15, 1, 1);
    step("add_max", 15, 15, 0, 1);
    for (int i = 0; i < 300; i++)
      step("rand", $urandom_range(15), $urandom_range(15), $urandom_range(3), $urandom_range(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
